// File: rtl/rv32i_boot_loader.sv
// rv32i_boot_loader
// Frames a little-endian byte stream into 32-bit words and writes the payload
// into instruction memory, starting at the core reset vector. The core is
// released from reset only after the frame checksum has been verified.
//
// Frame: MAGIC, LEN, LEN payload words, CHECKSUM (each word 4 bytes, LSB first)
//
// Ports
//   clk, reset                       clock, synchronous active-high reset
//   s_valid, s_ready, s_data         byte stream handshake
//   start                            re-arm request (DONE/ERROR only)
//   imem_we, imem_addr, imem_wdata   instruction memory write port
//   core_reset_n                     active-low reset to the core
//   busy, done, error, err_code      frame status
//   words_loaded                     payload words written so far
//
// state      | meaning
// -----------+-------------------------------------------------
// HDR_MAGIC  | waiting for / assembling the magic header word
// HDR_LEN    | assembling the payload length word
// PAYLOAD    | assembling payload words, one imem write each
// CHECKSUM   | assembling the checksum word, compare to sum
// DONE       | image verified, core released from reset
// ERROR      | frame rejected, err_code holds the reason
module rv32i_boot_loader #(
  parameter int          ADDR_WIDTH = 14,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter logic [31:0] MAGIC      = 32'h3233_5652
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [7:0]            s_data,
  input  logic                  start,
  output logic                  imem_we,
  output logic [31:0]           imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_reset_n,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int CW        = ADDR_WIDTH + 1;
  localparam int MAX_WORDS = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {
    HDR_MAGIC,
    HDR_LEN,
    PAYLOAD,
    CHECKSUM,
    DONE,
    ERROR
  } state_t;

  state_t        state, state_next;
  logic [1:0]    err_code_next;
  logic [1:0]    byte_idx;
  logic [23:0]   word_buf;
  logic [31:0]   sum;
  logic [CW-1:0] remaining;
  logic          xfer;
  logic          word_done;
  logic [31:0]   word_full;

  assign s_ready   = (state == HDR_MAGIC) || (state == HDR_LEN) ||
                     (state == PAYLOAD)   || (state == CHECKSUM);
  assign xfer      = s_valid && s_ready;
  assign word_done = xfer && (byte_idx == 2'd3);
  // The completing byte is still on the bus; the lower three come from word_buf.
  assign word_full = {s_data, word_buf};
  assign busy      = (state == HDR_LEN) || (state == PAYLOAD) || (state == CHECKSUM) ||
                     ((state == HDR_MAGIC) && (byte_idx != 2'd0));

  always_ff @(posedge clk) begin
    if (reset) state <= HDR_MAGIC;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    err_code_next = 2'd0;
    case (state)
      HDR_MAGIC: begin
        if (word_done) begin
          if (word_full == MAGIC) begin
            state_next = HDR_LEN;
          end else begin
            state_next    = ERROR;
            err_code_next = 2'd1;
          end
        end
      end
      HDR_LEN: begin
        if (word_done) begin
          if (word_full > 32'(MAX_WORDS)) begin
            state_next    = ERROR;
            err_code_next = 2'd2;
          end else if (word_full == 32'd0) begin
            state_next = CHECKSUM;
          end else begin
            state_next = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        // remaining counts down; terminal count 1 marks the last payload word.
        if (word_done && (remaining == CW'(1))) state_next = CHECKSUM;
      end
      CHECKSUM: begin
        if (word_done) begin
          if (word_full == sum) begin
            state_next = DONE;
          end else begin
            state_next    = ERROR;
            err_code_next = 2'd3;
          end
        end
      end
      DONE, ERROR: begin
        if (start) state_next = HDR_MAGIC;
      end
      default: state_next = HDR_MAGIC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_idx     <= 2'd0;
      word_buf     <= 24'd0;
      sum          <= 32'd0;
      remaining    <= '0;
      words_loaded <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= BASE_ADDR;
      imem_wdata   <= 32'd0;
      done         <= 1'b0;
      core_reset_n <= 1'b0;
      error        <= 1'b0;
      err_code     <= 2'd0;
    end else begin
      imem_we <= 1'b0;

      if (xfer) begin
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0:    word_buf[7:0]   <= s_data;
          2'd1:    word_buf[15:8]  <= s_data;
          2'd2:    word_buf[23:16] <= s_data;
          default: ;
        endcase
      end

      case (state)
        HDR_LEN: begin
          if (word_done) begin
            remaining    <= word_full[CW-1:0];
            sum          <= 32'd0;
            words_loaded <= '0;
          end
        end
        PAYLOAD: begin
          if (word_done) begin
            imem_we      <= 1'b1;
            imem_wdata   <= word_full;
            imem_addr    <= BASE_ADDR + {{(32-CW-2){1'b0}}, words_loaded, 2'b00};
            words_loaded <= words_loaded + CW'(1);
            sum          <= sum + word_full;
            remaining    <= remaining - CW'(1);
          end
        end
        DONE, ERROR: begin
          if (start) begin
            words_loaded <= '0;
            sum          <= 32'd0;
            byte_idx     <= 2'd0;
            err_code     <= 2'd0;
          end
        end
        default: ;
      endcase

      if ((state_next == ERROR) && (state != ERROR)) err_code <= err_code_next;

      // Status flags follow the state being entered so they rise with it.
      done         <= (state_next == DONE);
      core_reset_n <= (state_next == DONE);
      error        <= (state_next == ERROR);
    end
  end

endmodule

// File: tb/tb_rv32i_boot_loader.sv
module tb_rv32i_boot_loader;

  localparam int          ADDR_WIDTH = 14;
  localparam int          MAX_WORDS  = 2 ** ADDR_WIDTH;
  localparam logic [31:0] BASE       = 32'h8000_0000;
  localparam logic [31:0] MAGIC      = 32'h3233_5652;

  logic                clk = 1'b0;
  logic                reset;
  logic                s_valid;
  logic                s_ready;
  logic [7:0]          s_data;
  logic                start;
  logic                imem_we;
  logic [31:0]         imem_addr;
  logic [31:0]         imem_wdata;
  logic                core_reset_n;
  logic                busy;
  logic                done;
  logic                error;
  logic [1:0]          err_code;
  logic [ADDR_WIDTH:0] words_loaded;

  rv32i_boot_loader #(.ADDR_WIDTH(ADDR_WIDTH), .BASE_ADDR(BASE), .MAGIC(MAGIC)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .start(start), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_reset_n(core_reset_n), .busy(busy), .done(done), .error(error),
    .err_code(err_code), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_wr_t;
  exp_wr_t wr_q[$];
  exp_wr_t wr_e;

  typedef struct {
    logic [4:0][31:0] w;
    int               nw;
    bit               stall;
    bit               exp_done;
    bit               exp_err;
    logic [1:0]       exp_code;
    int               exp_words;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write scoreboard: every imem_we must match the oldest expected write,
  // including the cycle it was predicted for.
  always @(negedge clk) begin
    if (!reset && imem_we) begin
      if (wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", imem_addr, imem_wdata);
      end else begin
        wr_e = wr_q.pop_front();
        chk("wr_addr", imem_addr, wr_e.addr);
        chk("wr_data", imem_wdata, wr_e.data);
        chk("wr_latency_cycle", cyc, wr_e.cyc);
      end
    end
  end

  function automatic vec_t mk(input int nw, input bit stall, input bit d, input bit e,
                              input logic [1:0] code, input int words,
                              input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3,
                              input logic [31:0] w4);
    vec_t v;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3; v.w[4] = w4;
    v.nw = nw; v.stall = stall; v.exp_done = d; v.exp_err = e;
    v.exp_code = code; v.exp_words = words;
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b1; s_valid = 1'b0; s_data = 8'h00; start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wr_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    s_valid = 1'b1; s_data = b;
    @(posedge clk); #1;
  endtask

  // Byte 3 completes the word; the write is expected in the cycle that
  // follows the completing transfer, i.e. visible at the current cyc value.
  task automatic send_word(input logic [31:0] w, input bit pay, input logic [31:0] addr,
                           input bit stall);
    for (int b = 0; b < 4; b++) begin
      if (stall) begin
        int n = $urandom_range(0, 3);
        repeat (n) begin
          s_valid = 1'b0; s_data = 8'($urandom);
          @(posedge clk); #1;
        end
      end
      send_byte(w[8*b +: 8]);
      if (b == 3 && pay) wr_q.push_back('{addr: addr, data: w, cyc: cyc});
    end
    s_valid = 1'b0;
  endtask

  task automatic check_end(input string tag, input bit d, input bit e, input logic [1:0] code,
                           input int words);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({tag, "_done"}, 32'(done), 32'(d));
    chk({tag, "_core_reset_n"}, 32'(core_reset_n), 32'(d));
    chk({tag, "_error"}, 32'(error), 32'(e));
    chk({tag, "_err_code"}, 32'(err_code), 32'(code));
    chk({tag, "_words_loaded"}, 32'(words_loaded), 32'(words));
    chk({tag, "_s_ready"}, 32'(s_ready), 32'(!(d || e)));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_pending_writes"}, 32'(wr_q.size()), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    bit pay;
    logic [31:0] len;
    len = v.w[1];
    for (int k = 0; k < v.nw; k++) begin
      pay = (v.w[0] == MAGIC) && (len <= 32'(MAX_WORDS)) && (k >= 2) && (32'(k) < len + 32'd2);
      send_word(v.w[k], pay, BASE + 32'(4 * (k - 2)), v.stall);
    end
    check_end(tag, v.exp_done, v.exp_err, v.exp_code, v.exp_words);
  endtask

  initial begin
    vecs[0] = mk(5, 0, 1, 0, 2'd0, 2, MAGIC, 32'd2, 32'h0000_0093, 32'h0010_0113, 32'h0010_01A6);
    vecs[1] = mk(1, 0, 0, 1, 2'd1, 0, 32'hDEAD_BEEF, 32'd0, 32'd0, 32'd0, 32'd0);
    vecs[2] = mk(2, 0, 0, 1, 2'd2, 0, MAGIC, 32'd16385, 32'd0, 32'd0, 32'd0);
    vecs[3] = mk(3, 0, 1, 0, 2'd0, 0, MAGIC, 32'd0, 32'd0, 32'd0, 32'd0);
    vecs[4] = mk(4, 0, 0, 1, 2'd3, 1, MAGIC, 32'd1, 32'h1, 32'h2, 32'd0);
    vecs[5] = mk(5, 1, 1, 0, 2'd0, 2, MAGIC, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

    do_reset();
    @(negedge clk);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_imem_addr", imem_addr, BASE);
    chk("rst_imem_wdata", imem_wdata, 32'd0);
    chk("rst_core_reset_n", 32'(core_reset_n), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_words_loaded", 32'(words_loaded), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Bytes offered while in ERROR must not be consumed.
    do_reset();
    run_vec(vecs[1], "err_hold");
    repeat (3) send_byte(8'h52);
    s_valid = 1'b0;
    check_end("err_hold_after", 1'b0, 1'b1, 2'd1, 0);

    // Reset after 6 payload bytes discards everything.
    do_reset();
    send_word(MAGIC, 1'b0, 32'd0, 1'b0);
    send_word(32'd4, 1'b0, 32'd0, 1'b0);
    send_word(32'hAAAA_5555, 1'b1, BASE, 1'b0);
    send_byte(8'h11);
    send_byte(8'h22);
    s_valid = 1'b0;
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_words_loaded", 32'(words_loaded), 32'd1);
    chk("mid_pending_writes", 32'(wr_q.size()), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_words_loaded", 32'(words_loaded), 32'd0);
    chk("mid_rst_core_reset_n", 32'(core_reset_n), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_s_ready", 32'(s_ready), 32'd1);

    // Full frame right after the mid-frame reset, then bytes in DONE, then re-arm.
    run_vec(vecs[0], "after_rst");
    repeat (3) send_byte(8'h77);
    s_valid = 1'b0;
    check_end("done_hold", 1'b1, 1'b0, 2'd0, 2);
    #4 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("rearm_done", 32'(done), 32'd0);
    chk("rearm_core_reset_n", 32'(core_reset_n), 32'd0);
    chk("rearm_words_loaded", 32'(words_loaded), 32'd0);
    chk("rearm_s_ready", 32'(s_ready), 32'd1);

    send_word(MAGIC, 1'b0, 32'd0, 1'b0);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("start_ignored_busy", 32'(busy), 32'd1);
    send_word(32'd1, 1'b0, 32'd0, 1'b0);
    send_word(32'h1234_5678, 1'b1, BASE, 1'b0);
    send_word(32'h1234_5678, 1'b0, 32'd0, 1'b0);
    check_end("rearm_frame", 1'b1, 1'b0, 2'd0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
